// File: rtl/wishbone_arbiter_nmaster_if.sv
// Bus bundle joining N Wishbone masters, the arbiter and a single slave.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric's view.
interface wishbone_arbiter_nmaster_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic [NUM_MASTERS-1:0]            m_we_i;
    logic [NUM_MASTERS-1:0]            m_cyc_i;
    logic [NUM_MASTERS-1:0]            m_stb_i;
    logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_o;
    logic [NUM_MASTERS-1:0]            m_ack_o;
    logic [NUM_MASTERS-1:0]            m_err_o;
    logic [NUM_MASTERS-1:0]            m_int_o;
    logic                              s_we_o;
    logic                              s_cyc_o;
    logic                              s_stb_o;
    logic [SEL_WIDTH-1:0]              s_sel_o;
    logic [ADDR_WIDTH-1:0]             s_adr_o;
    logic [DATA_WIDTH-1:0]             s_dat_o;
    logic [DATA_WIDTH-1:0]             s_dat_i;
    logic                              s_ack_i;
    logic                              s_int_i;
    logic [NUM_MASTERS-1:0]            grant_o;
    logic                              busy_o;

    modport slave (
        input  m_we_i, m_cyc_i, m_stb_i, m_sel_i, m_adr_i, m_dat_i,
        input  s_dat_i, s_ack_i, s_int_i,
        output m_dat_o, m_ack_o, m_err_o, m_int_o,
        output s_we_o, s_cyc_o, s_stb_o, s_sel_o, s_adr_o, s_dat_o,
        output grant_o, busy_o
    );

    modport master (
        output m_we_i, m_cyc_i, m_stb_i, m_sel_i, m_adr_i, m_dat_i,
        output s_dat_i, s_ack_i, s_int_i,
        input  m_dat_o, m_ack_o, m_err_o, m_int_o,
        input  s_we_o, s_cyc_o, s_stb_o, s_sel_o, s_adr_o, s_dat_o,
        input  grant_o, busy_o
    );
endinterface

// File: rtl/wishbone_arbiter_nmaster.sv
// N-master to 1-slave Wishbone arbiter with a registered, cycle-long grant,
// fixed or round-robin priority and an optional no-ack watchdog.
module wishbone_arbiter_nmaster #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 0
) (
    input logic clk,
    input logic rst,
    wishbone_arbiter_nmaster_if.slave bus
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W     = $clog2(NUM_MASTERS);
    localparam int WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t                 state;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       last_grant;
    logic [WD_W-1:0]        wd_cnt;

    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       cand;
    logic                   found;
    logic                   active;
    logic                   g_cyc, g_stb, g_we;
    logic [SEL_WIDTH-1:0]   g_sel;
    logic [ADDR_WIDTH-1:0]  g_adr;
    logic [DATA_WIDTH-1:0]  g_dat;
    logic                   timeout_hit;

    logic [NUM_MASTERS-1:0]            ack_v, err_v, int_v;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] dat_v;

    // Search order starts just above the previous owner in round-robin mode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (ROUND_ROBIN != 0)
                cand = IDX_W'((int'(last_grant) + 1 + k) % NUM_MASTERS);
            else
                cand = IDX_W'(k);
            if (!found && bus.m_cyc_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign active = (state == GRANTED);
    assign g_cyc  = bus.m_cyc_i[grant_idx];
    assign g_stb  = bus.m_stb_i[grant_idx];
    assign g_we   = bus.m_we_i[grant_idx];
    assign g_sel  = bus.m_sel_i[grant_idx*SEL_WIDTH +: SEL_WIDTH];
    assign g_adr  = bus.m_adr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign g_dat  = bus.m_dat_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    // An ack arriving on the limit cycle wins over the watchdog.
    assign timeout_hit = (TIMEOUT > 0) && active && g_stb && !bus.s_ack_i &&
                         (wd_cnt == WD_W'(TIMEOUT - 1));

    assign bus.s_cyc_o = active && g_cyc && !timeout_hit;
    assign bus.s_stb_o = active && g_stb && !timeout_hit;
    assign bus.s_we_o  = active && g_we;
    assign bus.s_sel_o = active ? g_sel : '0;
    assign bus.s_adr_o = active ? g_adr : '0;
    assign bus.s_dat_o = active ? g_dat : '0;

    always_comb begin
        ack_v = '0;
        err_v = '0;
        int_v = '0;
        dat_v = '0;
        if (active) begin
            ack_v[grant_idx] = bus.s_ack_i;
            err_v[grant_idx] = timeout_hit;
            int_v[grant_idx] = bus.s_int_i;
            dat_v[grant_idx*DATA_WIDTH +: DATA_WIDTH] = bus.s_dat_i;
        end
    end

    assign bus.m_ack_o = ack_v;
    assign bus.m_err_o = err_v;
    assign bus.m_int_o = int_v;
    assign bus.m_dat_o = dat_v;
    assign bus.grant_o = grant;
    assign bus.busy_o  = active;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            grant_idx  <= '0;
            last_grant <= LAST_IDX;
            wd_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (|bus.m_cyc_i) begin
                        state     <= GRANTED;
                        grant     <= NUM_MASTERS'(1) << winner;
                        grant_idx <= winner;
                    end
                end
                GRANTED: begin
                    // Only the owner's own cyc drop or the watchdog ends the tenure.
                    if (!g_cyc || timeout_hit) begin
                        state      <= IDLE;
                        grant      <= '0;
                        last_grant <= grant_idx;
                        wd_cnt     <= '0;
                    end else if ((TIMEOUT > 0) && g_stb && !bus.s_ack_i) begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end else begin
                        wd_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wishbone_arbiter_nmaster.sv
// Randomised scoreboard bench: two arbiters (round-robin with watchdog, fixed priority
// without) each driven by random masters/slave; a transaction-level model predicts events.
module tb_wishbone_arbiter_nmaster;
  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int CW   = 256;
  localparam int NCYC = 3000;

  typedef struct {
    int unsigned     t;
    logic [N-1:0]    ack;
    logic [N-1:0]    err;
    logic [N-1:0]    intr;
    logic [N*DW-1:0] dat;
    logic            s_cyc;
    logic            s_stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   wdat;
    logic [SW-1:0]   sel;
  } beat_t;

  typedef struct {
    int unsigned  t;
    logic [N-1:0] grant;
  } gnt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  int n_vec = 0;
  int n_bad = 0;
  bit env_done [2];

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_env
    localparam int RR = (d == 0) ? 1 : 0;
    localparam int TO = (d == 0) ? 8 : 0;

    logic rst;
    wishbone_arbiter_nmaster_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wishbone_arbiter_nmaster #(
      .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .ROUND_ROBIN(RR), .TIMEOUT(TO)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    beat_t         beat_q[$];
    gnt_t          gnt_q[$];
    bit            mon_on = 1'b0;
    logic [N-1:0]  prev_g = '0;

    // Reference model state: current owner (-1 = none), previous owner, stall count.
    int            owner, last, wd;
    int            beats [N];
    int            idle  [N];
    bit            dead  [N];
    bit            stb_on[N];
    logic          we    [N];
    logic [AW-1:0] adr   [N];
    logic [DW-1:0] wdat  [N];
    logic [SW-1:0] sel   [N];

    function automatic int pick(input logic [N-1:0] req, input int from);
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (RR != 0) ? (from + k) % N : k - 1;
        if (req[c]) return c;
      end
      return -1;
    endfunction

    initial begin
      logic [N-1:0] cyc_v, stb_v;
      logic [DW-1:0] s_dat;
      logic s_int;
      bit ack, tmo, do_rst, tail;
      int cur, nxt;
      beat_t b;
      gnt_t g;

      owner = -1; last = N - 1; wd = 0;
      for (int i = 0; i < N; i++) begin
        beats[i] = 0; idle[i] = $urandom_range(0, 3); dead[i] = 0; stb_on[i] = 0;
      end
      rst = 1'b1;
      bus.m_cyc_i = '1; bus.m_stb_i = '1; bus.m_we_i = '1;
      bus.m_sel_i = '1;
      for (int i = 0; i < N; i++) begin
        bus.m_adr_i[i*AW +: AW] = $urandom;
        bus.m_dat_i[i*DW +: DW] = $urandom;
      end
      bus.s_ack_i = 1'b1; bus.s_int_i = 1'b1; bus.s_dat_i = $urandom;

      repeat (3) @(posedge clk);
      #1;
      check($sformatf("env%0d reset grant_o", d), bus.grant_o, '0);
      check($sformatf("env%0d reset busy_o", d), bus.busy_o, '0);
      check($sformatf("env%0d reset s_cyc_o", d), bus.s_cyc_o, '0);
      check($sformatf("env%0d reset s_stb_o", d), bus.s_stb_o, '0);
      check($sformatf("env%0d reset s_we_o", d), bus.s_we_o, '0);
      check($sformatf("env%0d reset s_sel_o", d), bus.s_sel_o, '0);
      check($sformatf("env%0d reset s_adr_o", d), bus.s_adr_o, '0);
      check($sformatf("env%0d reset s_dat_o", d), bus.s_dat_o, '0);
      check($sformatf("env%0d reset m_ack_o", d), bus.m_ack_o, '0);
      check($sformatf("env%0d reset m_err_o", d), bus.m_err_o, '0);
      check($sformatf("env%0d reset m_int_o", d), bus.m_int_o, '0);
      check($sformatf("env%0d reset m_dat_o", d), bus.m_dat_o, '0);

      rst = 1'b0;
      bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.s_ack_i = 1'b0; bus.s_int_i = 1'b0;
      mon_on = 1'b1;

      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk);
        #1;
        tail   = (c >= NCYC - 40);
        do_rst = !tail && ($urandom_range(0, 199) == 0);

        for (int i = 0; i < N; i++) begin
          if (beats[i] == 0) begin
            if (idle[i] > 0) idle[i]--;
            else if (!tail && $urandom_range(0, 1) == 1) begin
              beats[i] = $urandom_range(1, 4);
              adr[i]   = $urandom & ~32'h3;
              we[i]    = 1'($urandom_range(0, 1));
              wdat[i]  = $urandom;
              sel[i]   = SW'($urandom);
              dead[i]  = (TO > 0) && ($urandom_range(0, 7) == 0);
              stb_on[i] = 1'b0;
            end
          end
          if (beats[i] > 0 && !stb_on[i]) stb_on[i] = ($urandom_range(0, 3) != 0);
          cyc_v[i] = (beats[i] > 0);
          stb_v[i] = (beats[i] > 0) && stb_on[i];
          if (beats[i] > 0) begin
            bus.m_we_i[i]           = we[i];
            bus.m_sel_i[i*SW +: SW] = sel[i];
            bus.m_adr_i[i*AW +: AW] = adr[i];
            bus.m_dat_i[i*DW +: DW] = wdat[i];
          end else begin
            bus.m_we_i[i]           = 1'($urandom_range(0, 1));
            bus.m_sel_i[i*SW +: SW] = SW'($urandom);
            bus.m_adr_i[i*AW +: AW] = $urandom;
            bus.m_dat_i[i*DW +: DW] = $urandom;
          end
        end
        bus.m_cyc_i = cyc_v;
        bus.m_stb_i = stb_v;
        rst = do_rst;

        // Slave: random read data and interrupt, acks live strobes half the time.
        s_dat = $urandom;
        s_int = 1'($urandom_range(0, 1));
        ack = !do_rst && owner >= 0 && stb_v[owner] && !dead[owner] && ($urandom_range(0, 1) == 1);
        tmo = (TO > 0) && owner >= 0 && stb_v[owner] && !ack && (wd == TO - 1);
        bus.s_dat_i = s_dat;
        bus.s_int_i = s_int;
        bus.s_ack_i = ack;

        if (ack || tmo) begin
          b.t     = cyc_no;
          b.ack   = ack ? (N'(1) << owner) : '0;
          b.err   = tmo ? (N'(1) << owner) : '0;
          b.intr  = N'(s_int) << owner;
          b.dat   = '0;
          b.dat[owner*DW +: DW] = s_dat;
          b.s_cyc = ack;
          b.s_stb = ack;
          b.we    = we[owner];
          b.adr   = adr[owner];
          b.wdat  = wdat[owner];
          b.sel   = sel[owner];
          beat_q.push_back(b);
        end

        cur = owner;
        if (cur >= 0 && ack) begin
          beats[cur]--; adr[cur] += 4; wdat[cur] = $urandom; sel[cur] = SW'($urandom);
          stb_on[cur] = 1'b0;
          if (beats[cur] == 0) idle[cur] = $urandom_range(0, 3);
        end
        if (cur >= 0 && tmo) begin
          beats[cur] = 0; stb_on[cur] = 1'b0; idle[cur] = $urandom_range(0, 3);
        end

        nxt = owner;
        if (do_rst) begin
          nxt = -1; last = N - 1; wd = 0;
        end else if (owner < 0) begin
          wd = 0;
          if (cyc_v != 0) nxt = pick(cyc_v, last);
        end else if (!cyc_v[owner] || tmo) begin
          last = owner; nxt = -1; wd = 0;
        end else begin
          wd = (stb_v[owner] && !ack) ? wd + 1 : 0;
        end
        if (nxt != owner) begin
          g.t = cyc_no + 1;
          g.grant = (nxt < 0) ? '0 : (N'(1) << nxt);
          gnt_q.push_back(g);
        end
        owner = nxt;
      end

      @(negedge clk);
      @(posedge clk);
      #1;
      bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.s_ack_i = 1'b0; rst = 1'b0;
      @(negedge clk);
      mon_on = 1'b0;
      check($sformatf("env%0d pending beats", d), beat_q.size(), 0);
      check($sformatf("env%0d pending grants", d), gnt_q.size(), 0);
      env_done[d] = 1'b1;
    end

    // Beat monitor: every ack/err the DUT presents must match the next predicted event.
    always @(negedge clk) begin
      if (mon_on) begin
        beat_t e;
        while (beat_q.size() > 0 && beat_q[0].t < cyc_no) begin
          check($sformatf("env%0d missing beat time", d), cyc_no, beat_q[0].t);
          void'(beat_q.pop_front());
        end
        if (|bus.m_ack_o || |bus.m_err_o) begin
          if (beat_q.size() == 0 || beat_q[0].t != cyc_no) begin
            check($sformatf("env%0d unexpected ack/err at %0d", d, cyc_no),
                  {bus.m_err_o, bus.m_ack_o}, '0);
          end else begin
            e = beat_q.pop_front();
            check($sformatf("env%0d m_ack_o @%0d", d, cyc_no), bus.m_ack_o, e.ack);
            check($sformatf("env%0d m_err_o @%0d", d, cyc_no), bus.m_err_o, e.err);
            check($sformatf("env%0d m_int_o @%0d", d, cyc_no), bus.m_int_o, e.intr);
            check($sformatf("env%0d m_dat_o @%0d", d, cyc_no), bus.m_dat_o, e.dat);
            check($sformatf("env%0d s_cyc_o @%0d", d, cyc_no), bus.s_cyc_o, e.s_cyc);
            check($sformatf("env%0d s_stb_o @%0d", d, cyc_no), bus.s_stb_o, e.s_stb);
            check($sformatf("env%0d s_we_o @%0d", d, cyc_no), bus.s_we_o, e.we);
            check($sformatf("env%0d s_adr_o @%0d", d, cyc_no), bus.s_adr_o, e.adr);
            check($sformatf("env%0d s_dat_o @%0d", d, cyc_no), bus.s_dat_o, e.wdat);
            check($sformatf("env%0d s_sel_o @%0d", d, cyc_no), bus.s_sel_o, e.sel);
            check($sformatf("env%0d busy_o @%0d", d, cyc_no), bus.busy_o, 1'b1);
          end
        end
      end
    end

    // Grant monitor: every change of grant_o must match the next predicted ownership change.
    always @(negedge clk) begin
      if (mon_on) begin
        gnt_t e;
        while (gnt_q.size() > 0 && gnt_q[0].t < cyc_no) begin
          check($sformatf("env%0d missing grant change time", d), cyc_no, gnt_q[0].t);
          void'(gnt_q.pop_front());
        end
        if (bus.grant_o !== prev_g) begin
          if (gnt_q.size() == 0 || gnt_q[0].t != cyc_no) begin
            check($sformatf("env%0d unexpected grant change at %0d", d, cyc_no), bus.grant_o, prev_g);
          end else begin
            e = gnt_q.pop_front();
            check($sformatf("env%0d grant_o @%0d", d, cyc_no), bus.grant_o, e.grant);
            check($sformatf("env%0d busy_o @%0d", d, cyc_no), bus.busy_o, (e.grant != '0));
          end
          prev_g = bus.grant_o;
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < 20000 && !(env_done[0] && env_done[1]); c++) @(posedge clk);
    if (!(env_done[0] && env_done[1]))
      check("run completion", {env_done[1], env_done[0]}, 2'b11);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
